// File: rtl/arcade_input_conditioner.sv
// -----------------------------------------------------------------------------
// arcade_input_conditioner
//
// Conditions joystick-mux controls for the CRAZYBALLOON core (clk_sys domain):
// 2-flop synchronisers, per-bit debounce, optional opposite-direction cancel
// (SOCD), a frame-timed coin pulse shaper with a small press queue, and the
// active-low in0/in1 byte packing the core expects.
//
// Ports:
//   CLK          system clock (clk_sys)
//   RESET        synchronous, active-high reset (highest priority)
//   I_VBLANK     core vblank, already in the CLK domain (frame tick source)
//   I_JOY1[6:0]  P1 active-high {coin, start2, start1, up, down, left, right}
//   I_JOY2[3:0]  P2 active-high {up, down, left, right}
//   I_SOCD_EN    1 = cancel simultaneous opposite directions (quasi-static)
//   O_IN0[7:0]   {~P2R,~P2L,~P2D,~P2U,~P1R,~P1L,~P1D,~P1U}
//   O_IN1[7:0]   {1'b0, coin, ~S2, ~S1, 4'b1111}
//   O_COIN_BUSY  1 while a coin pulse/gap is running or presses are queued
// -----------------------------------------------------------------------------
module arcade_input_conditioner #(
    parameter int DEB_CYCLES      = 9987,
    parameter int COIN_FRAMES     = 3,
    parameter int COIN_GAP_FRAMES = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       I_VBLANK,
    input  logic [6:0] I_JOY1,
    input  logic [3:0] I_JOY2,
    input  logic       I_SOCD_EN,
    output logic [7:0] O_IN0,
    output logic [7:0] O_IN1,
    output logic       O_COIN_BUSY
);

    localparam int NB   = 11;
    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int FMAX = (COIN_FRAMES > COIN_GAP_FRAMES) ? COIN_FRAMES : COIN_GAP_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [FW-1:0] ACT_LAST = FW'(COIN_FRAMES - 1);
    localparam logic [FW-1:0] GAP_LAST = FW'(COIN_GAP_FRAMES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;
    localparam logic [1:0] QUEUE_MAX = 2'd3;

    // Bit positions inside the combined 11-bit control vector {I_JOY2, I_JOY1}
    localparam int B_P1R  = 0;
    localparam int B_P1L  = 1;
    localparam int B_P1D  = 2;
    localparam int B_P1U  = 3;
    localparam int B_S1   = 4;
    localparam int B_S2   = 5;
    localparam int B_COIN = 6;
    localparam int B_P2R  = 7;
    localparam int B_P2L  = 8;
    localparam int B_P2D  = 9;
    localparam int B_P2U  = 10;

    // Saturating increment of the coin press queue
    function automatic logic [1:0] queue_bump(input logic [1:0] q, input logic rise);
        logic [1:0] r;
        if (rise && (q != QUEUE_MAX)) begin
            r = q + 2'd1;
        end else begin
            r = q;
        end
        return r;
    endfunction

    logic [NB-1:0] joy_raw_s;
    logic [NB-1:0] s1_d, s1_q;
    logic [NB-1:0] s2_d, s2_q;
    logic [NB-1:0] stable_d, stable_q;
    logic [DW-1:0] cnt_d [NB];
    logic [DW-1:0] cnt_q [NB];

    logic          vblank_prev_d, vblank_prev_q;
    logic          coin_prev_d, coin_prev_q;
    logic          tick_s;
    logic          coin_rise_s;
    logic [1:0]    state_d, state_q;
    logic [FW-1:0] fcnt_d, fcnt_q;
    logic [1:0]    queue_d, queue_q;

    logic          p1_lr_cancel_s, p1_ud_cancel_s;
    logic          p2_lr_cancel_s, p2_ud_cancel_s;
    logic [7:0]    in0_d, in0_q;
    logic [7:0]    in1_d, in1_q;
    logic          busy_d, busy_q;

    assign joy_raw_s = {I_JOY2, I_JOY1};

    // Synchroniser chain and per-bit debounce counters
    always_comb begin
        s1_d     = joy_raw_s;
        s2_d     = s1_q;
        stable_d = stable_q;
        for (int i = 0; i < NB; i++) begin
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = {DW{1'b0}};
            end else if (cnt_q[i] == DEB_LAST) begin
                // DEB_CYCLES-th consecutive differing cycle: accept the level
                stable_d[i] = s2_q[i];
                cnt_d[i]    = {DW{1'b0}};
            end else begin
                cnt_d[i] = cnt_q[i] + DW'(1);
            end
        end
    end

    // Frame tick and debounced coin edge detection
    always_comb begin
        vblank_prev_d = I_VBLANK;
        coin_prev_d   = stable_q[B_COIN];
        tick_s        = I_VBLANK & ~vblank_prev_q;
        coin_rise_s   = stable_q[B_COIN] & ~coin_prev_q;
    end

    // Coin pulse FSM: IDLE -> ACTIVE (COIN_FRAMES ticks) -> GAP (COIN_GAP_FRAMES ticks)
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        queue_d = queue_q;
        case (state_q)
            ST_IDLE: begin
                if (coin_rise_s || (queue_q != 2'd0)) begin
                    state_d = ST_ACTIVE;
                    fcnt_d  = {FW{1'b0}};
                    // A fresh press is served directly; otherwise one queued press is consumed.
                    if (!coin_rise_s) begin
                        queue_d = queue_q - 2'd1;
                    end else begin
                        queue_d = queue_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (tick_s) begin
                    if (fcnt_q == ACT_LAST) begin
                        state_d = ST_GAP;
                        fcnt_d  = {FW{1'b0}};
                    end else begin
                        fcnt_d = fcnt_q + FW'(1);
                    end
                end else begin
                    fcnt_d = fcnt_q;
                end
                queue_d = queue_bump(queue_q, coin_rise_s);
            end
            ST_GAP: begin
                if (tick_s) begin
                    if (fcnt_q == GAP_LAST) begin
                        state_d = ST_IDLE;
                        fcnt_d  = {FW{1'b0}};
                    end else begin
                        fcnt_d = fcnt_q + FW'(1);
                    end
                end else begin
                    fcnt_d = fcnt_q;
                end
                // A press landing on the GAP->IDLE edge is still queued here.
                queue_d = queue_bump(queue_q, coin_rise_s);
            end
            default: begin
                state_d = ST_IDLE;
                fcnt_d  = {FW{1'b0}};
                queue_d = 2'd0;
            end
        endcase
    end

    // SOCD cancel and active-low output packing
    always_comb begin
        p1_lr_cancel_s = I_SOCD_EN & stable_q[B_P1L] & stable_q[B_P1R];
        p1_ud_cancel_s = I_SOCD_EN & stable_q[B_P1U] & stable_q[B_P1D];
        p2_lr_cancel_s = I_SOCD_EN & stable_q[B_P2L] & stable_q[B_P2R];
        p2_ud_cancel_s = I_SOCD_EN & stable_q[B_P2U] & stable_q[B_P2D];
        in0_d = {
            ~(stable_q[B_P2R] & ~p2_lr_cancel_s),
            ~(stable_q[B_P2L] & ~p2_lr_cancel_s),
            ~(stable_q[B_P2D] & ~p2_ud_cancel_s),
            ~(stable_q[B_P2U] & ~p2_ud_cancel_s),
            ~(stable_q[B_P1R] & ~p1_lr_cancel_s),
            ~(stable_q[B_P1L] & ~p1_lr_cancel_s),
            ~(stable_q[B_P1D] & ~p1_ud_cancel_s),
            ~(stable_q[B_P1U] & ~p1_ud_cancel_s)
        };
        in1_d  = {1'b0, (state_q == ST_ACTIVE), ~stable_q[B_S2], ~stable_q[B_S1], 4'b1111};
        busy_d = (state_q != ST_IDLE) || (queue_q != 2'd0);
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_q          <= {NB{1'b0}};
            s2_q          <= {NB{1'b0}};
            stable_q      <= {NB{1'b0}};
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= {DW{1'b0}};
            end
            vblank_prev_q <= 1'b0;
            coin_prev_q   <= 1'b0;
            state_q       <= ST_IDLE;
            fcnt_q        <= {FW{1'b0}};
            queue_q       <= 2'd0;
            in0_q         <= 8'hFF;
            in1_q         <= 8'h3F;
            busy_q        <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            stable_q      <= stable_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            vblank_prev_q <= vblank_prev_d;
            coin_prev_q   <= coin_prev_d;
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            queue_q       <= queue_d;
            in0_q         <= in0_d;
            in1_q         <= in1_d;
            busy_q        <= busy_d;
        end
    end

    assign O_IN0       = in0_q;
    assign O_IN1       = in1_q;
    assign O_COIN_BUSY = busy_q;

endmodule

// File: tb/tb_arcade_input_conditioner.sv
// -----------------------------------------------------------------------------
// Testbench for arcade_input_conditioner (DEB_CYCLES=4, COIN_FRAMES=3,
// COIN_GAP_FRAMES=2, vblank rising every 50 cycles). A behavioural model keeps
// a window of synchronised samples (a level is accepted once the last
// DEB_CYCLES samples all disagree with it) and a tick-countdown coin engine
// with a pending-press count.
// -----------------------------------------------------------------------------
module tb_arcade_input_conditioner;

    localparam int DEB       = 4;
    localparam int CF        = 3;
    localparam int CG        = 2;
    localparam int VB_PERIOD = 50;
    localparam int VB_HIGH   = 5;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       vblank = 1'b0;
    logic [6:0] joy1   = 7'd0;
    logic [3:0] joy2   = 4'd0;
    logic       socd   = 1'b0;
    logic [7:0] in0;
    logic [7:0] in1;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int vb_phase = 0;

    // Model state
    logic [10:0] m_s1 = 11'd0;
    logic [10:0] m_s2 = 11'd0;
    logic [10:0] m_stable = 11'd0;
    logic [10:0] m_hist [DEB];
    logic        m_coin_prev = 1'b0;
    logic        m_vb_prev = 1'b0;
    int          m_pend = 0;
    int          m_hi = 0;
    int          m_lo = 0;
    logic [7:0]  m_in0 = 8'hFF;
    logic [7:0]  m_in1 = 8'h3F;
    logic        m_busy = 1'b0;

    arcade_input_conditioner #(
        .DEB_CYCLES     (DEB),
        .COIN_FRAMES    (CF),
        .COIN_GAP_FRAMES(CG)
    ) dut (
        .CLK        (clk),
        .RESET      (rst),
        .I_VBLANK   (vblank),
        .I_JOY1     (joy1),
        .I_JOY2     (joy2),
        .I_SOCD_EN  (socd),
        .O_IN0      (in0),
        .O_IN1      (in1),
        .O_COIN_BUSY(busy)
    );

    always #5 clk = ~clk;

    // Free-running vblank: high for VB_HIGH of every VB_PERIOD cycles
    initial begin
        forever begin
            @(negedge clk);
            vb_phase = (vb_phase + 1) % VB_PERIOD;
            vblank   = (vb_phase < VB_HIGH);
        end
    end

    function automatic logic [7:0] exp_in0(input logic [10:0] st, input logic en);
        logic p1u, p1d, p1l, p1r, p2u, p2d, p2l, p2r;
        p1u = st[3];  p1d = st[2]; p1l = st[1]; p1r = st[0];
        p2u = st[10]; p2d = st[9]; p2l = st[8]; p2r = st[7];
        if (en && p1l && p1r) begin p1l = 1'b0; p1r = 1'b0; end
        if (en && p1u && p1d) begin p1u = 1'b0; p1d = 1'b0; end
        if (en && p2l && p2r) begin p2l = 1'b0; p2r = 1'b0; end
        if (en && p2u && p2d) begin p2u = 1'b0; p2d = 1'b0; end
        return ~{p2r, p2l, p2d, p2u, p1r, p1l, p1d, p1u};
    endfunction

    // Reference model, advanced once per rising edge
    initial begin
        logic        press;
        logic        tick;
        logic        all_diff;
        logic [10:0] seen;
        for (int j = 0; j < DEB; j++) m_hist[j] = 11'd0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_s1 = 11'd0; m_s2 = 11'd0; m_stable = 11'd0;
                for (int j = 0; j < DEB; j++) m_hist[j] = 11'd0;
                m_coin_prev = 1'b0; m_vb_prev = 1'b0;
                m_pend = 0; m_hi = 0; m_lo = 0;
                m_in0 = 8'hFF; m_in1 = 8'h3F; m_busy = 1'b0;
            end else begin
                m_in0  = exp_in0(m_stable, socd);
                m_in1  = {1'b0, (m_hi > 0), ~m_stable[5], ~m_stable[4], 4'hF};
                m_busy = (m_hi > 0) || (m_lo > 0) || (m_pend > 0);
                press  = m_stable[6] & ~m_coin_prev;
                tick   = vblank & ~m_vb_prev;
                if (m_hi > 0) begin
                    if (tick) begin
                        m_hi--;
                        if (m_hi == 0) m_lo = CG;
                    end
                    if (press && m_pend < 3) m_pend++;
                end else if (m_lo > 0) begin
                    if (tick) m_lo--;
                    if (press && m_pend < 3) m_pend++;
                end else if (press || m_pend > 0) begin
                    m_hi = CF;
                    if (!press) m_pend--;
                end
                m_coin_prev = m_stable[6];
                m_vb_prev   = vblank;
                seen = m_s2;
                for (int j = DEB - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
                m_hist[0] = seen;
                for (int b = 0; b < 11; b++) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < DEB; j++) begin
                        if (m_hist[j][b] == m_stable[b]) all_diff = 1'b0;
                    end
                    if (all_diff) m_stable[b] = ~m_stable[b];
                end
                m_s2 = m_s1;
                m_s1 = {joy2, joy1};
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; joy1 = 7'd0; joy2 = 4'd0; socd = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (in0 !== 8'hFF) begin n_fail++; $display("FAIL reset_in0 got=%h exp=ff", in0); end
        n_checks++; if (in1 !== 8'h3F) begin n_fail++; $display("FAIL reset_in1 got=%h exp=3f", in1); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if ({in0, in1, busy} !== {m_in0, m_in1, m_busy}) begin
                n_fail++;
                $display("FAIL reset_idle got=%h/%h/%b exp=%h/%h/%b", in0, in1, busy, m_in0, m_in1, m_busy);
            end
        end
    endtask

    task automatic test_debounce();
        logic [7:0] exp;
        logic       saw;
        joy1[3] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            exp = (e >= DEB + 3) ? 8'hFE : 8'hFF;
            n_checks++;
            if (in0 !== exp) begin n_fail++; $display("FAIL deb_latency edge=%0d got=%h exp=%h", e, in0, exp); end
        end
        joy1[3] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_checks++;
            if ({in0, in1, busy} !== {m_in0, m_in1, m_busy}) begin
                n_fail++;
                $display("FAIL deb_release got=%h/%h/%b exp=%h/%h/%b", in0, in1, busy, m_in0, m_in1, m_busy);
            end
        end
        // 3-cycle glitch must be rejected
        joy2[0] = 1'b1;
        repeat (3) @(negedge clk);
        joy2[0] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_checks++;
            if (in0 !== 8'hFF) begin n_fail++; $display("FAIL deb_glitch got=%h exp=ff", in0); end
        end
        // 4-cycle pulse is exactly long enough to be accepted
        saw = 1'b0;
        joy2[0] = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 3) joy2[0] = 1'b0;
            if (in0 == 8'h7F) saw = 1'b1;
            n_checks++;
            if ({in0, in1, busy} !== {m_in0, m_in1, m_busy}) begin
                n_fail++;
                $display("FAIL deb_min_pulse got=%h/%h/%b exp=%h/%h/%b", in0, in1, busy, m_in0, m_in1, m_busy);
            end
        end
        n_checks++;
        if (saw !== 1'b1) begin n_fail++; $display("FAIL deb_min_accept got=%b exp=1", saw); end
    endtask

    task automatic test_socd();
        socd = 1'b1; joy1[1:0] = 2'b11;
        repeat (10) @(negedge clk);
        n_checks++; if (in0 !== 8'hFF) begin n_fail++; $display("FAIL socd_lr_on got=%h exp=ff", in0); end
        socd = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (in0 !== 8'hF3) begin n_fail++; $display("FAIL socd_lr_off got=%h exp=f3", in0); end
        joy1[1:0] = 2'b00;
        repeat (10) @(negedge clk);
        joy1[3:2] = 2'b11; socd = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++; if (in0 !== 8'hFF) begin n_fail++; $display("FAIL socd_ud_on got=%h exp=ff", in0); end
        socd = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (in0 !== 8'hFC) begin n_fail++; $display("FAIL socd_ud_off got=%h exp=fc", in0); end
        joy1[3:2] = 2'b00; joy2 = 4'b0011;
        repeat (10) @(negedge clk);
        n_checks++; if (in0 !== 8'h3F) begin n_fail++; $display("FAIL socd_p2_off got=%h exp=3f", in0); end
        socd = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (in0 !== 8'hFF) begin n_fail++; $display("FAIL socd_p2_on got=%h exp=ff", in0); end
        joy2 = 4'd0; socd = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_starts();
        logic [7:0] exp;
        joy1[5:4] = 2'b11;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            exp = (e >= DEB + 3) ? 8'h0F : 8'h3F;
            n_checks++;
            if (in1 !== exp) begin n_fail++; $display("FAIL starts edge=%0d got=%h exp=%h", e, in1, exp); end
        end
        socd = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++; if (in1 !== 8'h0F) begin n_fail++; $display("FAIL starts_socd got=%h exp=0f", in1); end
        joy1[5:4] = 2'b00; socd = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_held_coin();
        int   pulses;
        logic prev;
        pulses = 0; prev = 1'b0;
        joy1[6] = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            n_checks++;
            if (in1[6] !== (e >= DEB + 4)) begin
                n_fail++; $display("FAIL coin_rise edge=%0d got=%b exp=%b", e, in1[6], (e >= DEB + 4));
            end
            if (in1[6] && !prev) pulses++;
            prev = in1[6];
        end
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (in1[6] && !prev) pulses++;
            prev = in1[6];
            n_checks++;
            if ({in0, in1, busy} !== {m_in0, m_in1, m_busy}) begin
                n_fail++;
                $display("FAIL coin_held got=%h/%h/%b exp=%h/%h/%b", in0, in1, busy, m_in0, m_in1, m_busy);
            end
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL coin_held_pulses got=%0d exp=1", pulses); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL coin_held_busy got=%b exp=0", busy); end
        joy1[6] = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_queue();
        int   pulses;
        logic prev;
        pulses = 0; prev = in1[6];
        for (int c = 0; c < 1680; c++) begin
            joy1[6] = (c < 80) && ((c % 16) < 8);
            @(negedge clk);
            if (in1[6] && !prev) pulses++;
            prev = in1[6];
            n_checks++;
            if ({in0, in1, busy} !== {m_in0, m_in1, m_busy}) begin
                n_fail++;
                $display("FAIL coin_queue c=%0d got=%h/%h/%b exp=%h/%h/%b", c, in0, in1, busy, m_in0, m_in1, m_busy);
            end
        end
        n_checks++; if (pulses != 4) begin n_fail++; $display("FAIL coin_queue_pulses got=%0d exp=4", pulses); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL coin_queue_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_active();
        // One served press plus two queued, then reset during the pulse
        for (int c = 0; c < 48; c++) begin
            joy1[6] = ((c % 16) < 8);
            @(negedge clk);
            n_checks++;
            if ({in0, in1, busy} !== {m_in0, m_in1, m_busy}) begin
                n_fail++;
                $display("FAIL mid_setup got=%h/%h/%b exp=%h/%h/%b", in0, in1, busy, m_in0, m_in1, m_busy);
            end
        end
        joy1[6] = 1'b0;
        n_checks++; if (in1[6] !== 1'b1) begin n_fail++; $display("FAIL mid_active got=%b exp=1", in1[6]); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (in0 !== 8'hFF) begin n_fail++; $display("FAIL mid_reset_in0 got=%h exp=ff", in0); end
        n_checks++; if (in1 !== 8'h3F) begin n_fail++; $display("FAIL mid_reset_in1 got=%h exp=3f", in1); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            n_checks++;
            if (in1 !== 8'h3F || busy !== 1'b0) begin
                n_fail++; $display("FAIL mid_no_pulse got=%h/%b exp=3f/0", in1, busy);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                joy1 = 7'($urandom);
                joy2 = 4'($urandom);
                hold = $urandom_range(1, 9);
                if ($urandom_range(0, 15) == 0) socd = ~socd;
            end else begin
                hold--;
            end
            rst = ($urandom_range(0, 599) == 0);
            @(negedge clk);
            n_checks++;
            if ({in0, in1, busy} !== {m_in0, m_in1, m_busy}) begin
                n_fail++;
                $display("FAIL random c=%0d got=%h/%h/%b exp=%h/%h/%b", c, in0, in1, busy, m_in0, m_in1, m_busy);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_socd();
        test_starts();
        test_held_coin();
        test_queue();
        test_reset_mid_active();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
